// File: rtl/game_pkg.sv
// Shared types and constants for the sprite compositor: sprite word layout, FSM states
// and BCD score helpers.
package game_pkg;

    localparam int unsigned SPRITE_W = 25;
    localparam int unsigned RGB_W    = 24;
    localparam logic [15:0] BCD_MAX  = 16'h9999;

    typedef struct packed {
        logic [RGB_W-1:0] rgb;
        logic             valid;
    } sprite_t;

    typedef enum logic [1:0] {
        StActive,
        StWait,
        StUpdate,
        StOver
    } state_e;

    // Returns {carry_out, digit} for one BCD digit position.
    function automatic logic [4:0] bcd_digit_add(input logic [3:0] a, input logic [3:0] b,
                                                 input logic cin);
        logic [4:0] s;
        s = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        if (s > 5'd9) begin
            return {1'b1, s[3:0] + 4'd6};
        end
        return s;
    endfunction

endpackage

// File: rtl/bcd_add_sat.sv
// Four-digit combinational BCD adder; any carry out of the top digit saturates the
// result to 9999.
module bcd_add_sat
    import game_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum
);

    logic [15:0] raw;
    logic [4:0]  digit;
    logic        carry;

    always_comb begin
        raw   = '0;
        digit = '0;
        carry = 1'b0;
        for (int i = 0; i < 4; i++) begin
            digit            = bcd_digit_add(a[i*4 +: 4], b[i*4 +: 4], carry);
            raw[i*4 +: 4]    = digit[3:0];
            carry            = digit[4];
        end
        sum = carry ? BCD_MAX : raw;
    end

endmodule

// File: rtl/sprite_compositor.sv
// Layer mixer, bullet/enemy collision flag and per-frame score/life accounting.
// Define SPRITE_COMPOSITOR_PLAYER_HIT_EN to let player/enemy overlaps cost lives.
module sprite_compositor
    import game_pkg::*;
#(
    parameter logic [15:0] POINTS = 16'h0010,
    parameter int unsigned LIVES  = 3
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [11:0]         display_col,
    input  logic [10:0]         display_row,
    input  logic                calc,
    input  logic [SPRITE_W-1:0] enemy_color,
    input  logic [SPRITE_W-1:0] player_color,
    input  logic [SPRITE_W-1:0] bullet_color,
    input  logic [RGB_W-1:0]    background,
    output logic [RGB_W-1:0]    pixel,
    output logic                hit,
    output logic                bullet_clear,
    output logic [15:0]         score,
    output logic [1:0]          lives,
    output logic                game_over
);

    localparam logic [1:0] LIVES_INIT = 2'(LIVES);

    sprite_t enemy_s, player_s, bullet_s;

    state_e           state_q, state_d;
    logic             calc_q;
    logic [RGB_W-1:0] pixel_q, pixel_d;
    logic             hit_q, hit_now;
    logic             hit_seen_q, hit_seen_d;
    logic [15:0]      score_q, score_d, score_sum;
    logic             lives_zero;

    // Position is implied by upstream alignment; the compositor itself is position-free.
    logic unused_pos;
    assign unused_pos = ^{display_col, display_row};

    assign enemy_s  = enemy_color;
    assign player_s = player_color;
    assign bullet_s = bullet_color;

    assign hit_now = !calc && bullet_s.valid && enemy_s.valid && (state_q != StOver);

    always_comb begin
        pixel_d = '0;
        if (!calc) begin
            if (bullet_s.valid) begin
                pixel_d = bullet_s.rgb;
            end else if (player_s.valid) begin
                pixel_d = player_s.rgb;
            end else if (enemy_s.valid) begin
                pixel_d = enemy_s.rgb;
            end else begin
                pixel_d = background;
            end
        end
    end

    bcd_add_sat u_score_add (
        .a   (score_q),
        .b   (POINTS),
        .sum (score_sum)
    );

`ifdef SPRITE_COMPOSITOR_PLAYER_HIT_EN
    logic       pl_seen_q, pl_seen_d;
    logic [1:0] lives_q, lives_d;

    always_comb begin
        pl_seen_d = pl_seen_q;
        lives_d   = lives_q;
        if (state_q == StActive) begin
            if (!calc && player_s.valid && enemy_s.valid) begin
                pl_seen_d = 1'b1;
            end
        end else if (state_q == StUpdate) begin
            pl_seen_d = 1'b0;
            if (pl_seen_q && (lives_q != 2'd0)) begin
                lives_d = lives_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pl_seen_q <= 1'b0;
            lives_q   <= LIVES_INIT;
        end else begin
            pl_seen_q <= pl_seen_d;
            lives_q   <= lives_d;
        end
    end

    assign lives_zero = (lives_d == 2'd0);
    assign lives      = lives_q;
    assign game_over  = (state_q == StOver);
`else
    assign lives_zero = 1'b0;
    assign lives      = LIVES_INIT;
    assign game_over  = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        hit_seen_d   = hit_seen_q;
        score_d      = score_q;
        bullet_clear = 1'b0;
        unique case (state_q)
            StActive: begin
                if (hit_now) begin
                    hit_seen_d = 1'b1;
                end
                if (calc && !calc_q) begin
                    state_d = StUpdate;
                end
            end
            StUpdate: begin
                if (hit_seen_q) begin
                    score_d      = score_sum;
                    bullet_clear = 1'b1;
                end
                hit_seen_d = 1'b0;
                // A calc pulse that already ended skips WAIT so its falling edge is not lost.
                if (lives_zero) begin
                    state_d = StOver;
                end else if (calc) begin
                    state_d = StWait;
                end else begin
                    state_d = StActive;
                end
            end
            StWait: begin
                if (!calc && calc_q) begin
                    state_d = StActive;
                end
            end
            StOver: begin
            end
            default: state_d = StWait;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= StWait;
            calc_q     <= 1'b0;
            pixel_q    <= '0;
            hit_q      <= 1'b0;
            hit_seen_q <= 1'b0;
            score_q    <= '0;
        end else begin
            state_q    <= state_d;
            calc_q     <= calc;
            pixel_q    <= pixel_d;
            hit_q      <= hit_now;
            hit_seen_q <= hit_seen_d;
            score_q    <= score_d;
        end
    end

    assign pixel = pixel_q;
    assign hit   = hit_q;
    assign score = score_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Scoreboard bench for sprite_compositor: directed pixels and frames push expectations,
// a monitor pops one per cycle and compares.
module tb_sprite_compositor;

`ifdef SPRITE_COMPOSITOR_PLAYER_HIT_EN
    localparam bit PH = 1'b1;
`else
    localparam bit PH = 1'b0;
`endif

    localparam logic [24:0] N  = 25'h0;
    localparam logic [24:0] B  = {24'hFF0000, 1'b1};
    localparam logic [24:0] P  = {24'h00FF00, 1'b1};
    localparam logic [24:0] E  = {24'h0000FF, 1'b1};
    localparam logic [24:0] B0 = {24'hFF0000, 1'b0};
    localparam logic [24:0] P0 = {24'h00FF00, 1'b0};
    localparam logic [24:0] E0 = {24'h0000FF, 1'b0};
    localparam logic [23:0] BG = 24'h123456;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] display_col = '0;
    logic [10:0] display_row = '0;
    logic        calc = 1'b0;
    logic [24:0] enemy_color = '0;
    logic [24:0] player_color = '0;
    logic [24:0] bullet_color = '0;
    logic [23:0] background = BG;
    logic [23:0] pixel;
    logic        hit;
    logic        bullet_clear;
    logic [15:0] score;
    logic [1:0]  lives;
    logic        game_over;

    sprite_compositor dut (
        .clock        (clock),
        .reset        (reset),
        .display_col  (display_col),
        .display_row  (display_row),
        .calc         (calc),
        .enemy_color  (enemy_color),
        .player_color (player_color),
        .bullet_color (bullet_color),
        .background   (background),
        .pixel        (pixel),
        .hit          (hit),
        .bullet_clear (bullet_clear),
        .score        (score),
        .lives        (lives),
        .game_over    (game_over)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [23:0] pix;
        logic        hit;
        bit          chk_stat;
        logic [15:0] score;
        logic [1:0]  lives;
        logic        go;
        logic        bc;
    } exp_t;

    exp_t sb[$];
    int total = 0;
    int bad = 0;

    logic [15:0] exp_score = 16'h0000;
    logic [1:0]  exp_lives = 2'd3;
    logic        exp_go = 1'b0;
    bit          st_pending = 1'b0;
    logic        st_bc = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // One pixel cycle; the expectation is checked on the following cycle.
    task automatic cyc(input logic c, input logic [24:0] b, input logic [24:0] p,
                       input logic [24:0] e, input logic [23:0] xpix, input logic xhit,
                       input string nm);
        exp_t x;
        @(posedge clock);
        #2;
        calc         = c;
        bullet_color = b;
        player_color = p;
        enemy_color  = e;
        display_col  = display_col + 12'd1;
        x.name     = nm;
        x.pix      = xpix;
        x.hit      = xhit;
        x.chk_stat = st_pending;
        x.score    = exp_score;
        x.lives    = exp_lives;
        x.go       = exp_go;
        x.bc       = st_bc;
        sb.push_back(x);
        st_pending = 1'b0;
    endtask

    // calc high for two cycles then low: UPDATE is observed during the second calc cycle.
    task automatic frame_end(input logic hs, input logic [15:0] ns, input logic [1:0] nl,
                             input logic ngo, input string nm);
        st_pending = 1'b1;
        st_bc      = hs;
        cyc(1'b1, N, N, N, 24'h0, 1'b0, {nm, "/upd"});
        exp_score  = ns;
        exp_lives  = nl;
        exp_go     = ngo;
        st_pending = 1'b1;
        st_bc      = 1'b0;
        cyc(1'b1, N, N, N, 24'h0, 1'b0, {nm, "/post"});
        cyc(1'b0, N, N, N, BG, 1'b0, {nm, "/fall"});
    endtask

    initial begin
        exp_t x;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                x = sb.pop_front();
                chk({x.name, " pixel"}, 32'(pixel), 32'(x.pix));
                chk({x.name, " hit"}, 32'(hit), 32'(x.hit));
                if (x.chk_stat) begin
                    chk({x.name, " score"}, 32'(score), 32'(x.score));
                    chk({x.name, " lives"}, 32'(lives), 32'(x.lives));
                    chk({x.name, " game_over"}, 32'(game_over), 32'(x.go));
                    chk({x.name, " bullet_clear"}, 32'(bullet_clear), 32'(x.bc));
                end
            end
        end
    end

    initial begin
        int dec;
        repeat (2) @(posedge clock);
        #3;
        chk("reset pixel", 32'(pixel), 32'h0);
        chk("reset hit", 32'(hit), 32'h0);
        chk("reset bullet_clear", 32'(bullet_clear), 32'h0);
        chk("reset score", 32'(score), 32'h0);
        chk("reset lives", 32'(lives), 32'd3);
        chk("reset game_over", 32'(game_over), 32'h0);
        reset = 1'b0;

        // Partial first frame (WAIT): composited but not scored.
        cyc(1'b0, B, P, E, 24'hFF0000, 1'b1, "prio bullet");
        cyc(1'b0, B0, P, E, 24'h00FF00, 1'b0, "prio player");
        cyc(1'b0, B0, P0, E, 24'h0000FF, 1'b0, "prio enemy");
        cyc(1'b0, B0, P0, E0, BG, 1'b0, "prio background");
        cyc(1'b1, B, P, E, 24'h0, 1'b0, "calc blank");
        cyc(1'b0, N, N, N, BG, 1'b0, "sync fall");

        for (int i = 0; i < 3; i++) cyc(1'b0, B, N, E, 24'hFF0000, 1'b1, "hit px");
        cyc(1'b0, N, N, E, 24'h0000FF, 1'b0, "enemy only");
        frame_end(1'b1, 16'h0010, 2'd3, 1'b0, "hit frame");

        cyc(1'b0, N, P, N, 24'h00FF00, 1'b0, "quiet px");
        frame_end(1'b0, 16'h0010, 2'd3, 1'b0, "quiet frame");

        cyc(1'b0, N, P, E, 24'h00FF00, 1'b0, "pl px1");
        frame_end(1'b0, 16'h0010, PH ? 2'd2 : 2'd3, 1'b0, "pl frame1");
        cyc(1'b0, N, P, E, 24'h00FF00, 1'b0, "pl px2");
        frame_end(1'b0, 16'h0010, PH ? 2'd1 : 2'd3, 1'b0, "pl frame2");
        cyc(1'b0, B, P, E, 24'hFF0000, 1'b1, "both px");
        frame_end(1'b1, 16'h0020, PH ? 2'd0 : 2'd3, PH, "both frame");

        cyc(1'b0, B, N, E, 24'hFF0000, !PH, "over px");
        frame_end(!PH, PH ? 16'h0020 : 16'h0030, exp_lives, exp_go, "over frame");

        // Asynchronous reset in the middle of a visible line.
        cyc(1'b0, B, N, E, 24'hFF0000, !PH, "pre reset px");
        @(posedge clock);
        #3;
        reset = 1'b1;
        #1;
        chk("midreset pixel", 32'(pixel), 32'h0);
        chk("midreset hit", 32'(hit), 32'h0);
        chk("midreset score", 32'(score), 32'h0);
        chk("midreset lives", 32'(lives), 32'd3);
        chk("midreset game_over", 32'(game_over), 32'h0);
        chk("midreset bullet_clear", 32'(bullet_clear), 32'h0);
        exp_score = 16'h0000;
        exp_lives = 2'd3;
        exp_go    = 1'b0;
        @(posedge clock);
        #3;
        reset = 1'b0;

        cyc(1'b0, B, N, E, 24'hFF0000, 1'b1, "partial hit px");
        frame_end(1'b0, 16'h0000, 2'd3, 1'b0, "partial frame");
        cyc(1'b0, B, N, E, 24'hFF0000, 1'b1, "live px");
        frame_end(1'b1, 16'h0010, 2'd3, 1'b0, "live frame");

        dec = 10;
        for (int f = 0; f < 1000; f++) begin
            cyc(1'b0, B, N, E, 24'hFF0000, 1'b1, "sat px");
            dec = (dec + 10 > 9999) ? 9999 : dec + 10;
            frame_end(1'b1, to_bcd(dec), 2'd3, 1'b0, "sat frame");
        end

        repeat (2) @(posedge clock);
        #3;
        chk("scoreboard drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
